// File: rtl/param_data_memory_pkg.sv
// Shared types and helpers for param_data_memory.
// Holds the two-state FSM encoding and the init fill pattern function.
package param_data_memory_pkg;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_e;

  // Init fill value for word k in a 2**addr_w array of data_w-bit words:
  // ascending k in the lower half, (half - k) wrapping in the upper half.
  // The result is 32 bits wide; callers truncate to their data width.
  function automatic logic [31:0] pattern(input logic [31:0] k,
                                          input int unsigned addr_w,
                                          input int unsigned data_w);
    logic [31:0] half;
    logic [31:0] val;
    half = 32'd1 << (addr_w - 1);
    if (k < half) val = k;
    else          val = half - k;
    if (data_w < 32) val = val & ((32'd1 << data_w) - 32'd1);
    return val;
  endfunction

endpackage

// File: rtl/param_mem_array.sv
// Single-port-write storage array with a registered read port, no reset.
// Ports: clk; we/waddr/wdata write port (synchronous);
//        re/raddr read request, rdata updated on the edge where re = 1
//        and held otherwise (read-before-write on a shared edge).
module param_mem_array #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Write and registered read share the edge; the read sees the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/param_data_memory.sv
// Parameterised data memory with a self-filling init engine.
// After reset (or an init_req pulse in IDLE) the engine spends DEPTH cycles
// writing pattern(k) to every word, then requests are served with a
// one-cycle read latency.
// Ports: clk, reset (async, active-high); init_req re-init pulse;
//        req_valid/req_ready handshake with req_we, req_addr, req_wdata;
//        rsp_valid/rsp_rdata read response; busy = init engine active.
module param_data_memory
  import param_data_memory_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_req,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rsp_valid_q;
  logic              rd_seen_q;
  logic              accept;
  logic              rd_accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  assign req_ready = (state_q == IDLE) && !init_req;
  assign accept    = req_valid && req_ready;
  assign rd_accept = accept && !req_we;
  assign busy      = (state_q == INIT);
  assign rsp_valid = rsp_valid_q;
  // The array has no reset, so the visible read data is forced to zero
  // until the first read after reset has loaded the array output register.
  assign rsp_rdata = rd_seen_q ? mem_rdata : '0;

  // State, init counter and response-valid registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rd_seen_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rd_accept;
      if (rd_accept) rd_seen_q <= 1'b1;
    end
  end

  // Next-state: walk cnt through every word in INIT, re-enter on init_req.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
      end
      IDLE: begin
        if (init_req) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Write-port mux: the init engine owns the port for the whole of INIT.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = req_addr;
    mem_wdata = req_wdata;
    if (state_q == INIT) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = DATA_W'(pattern(32'(cnt_q), ADDR_W, DATA_W));
    end else if (accept && req_we) begin
      mem_we = 1'b1;
    end
  end

  param_mem_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .waddr(mem_waddr),
    .wdata(mem_wdata),
    .re   (rd_accept),
    .raddr(req_addr),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_param_data_memory.sv
// Scoreboard bench for param_data_memory (DATA_W=8, ADDR_W=5).
module tb_param_data_memory;

  logic       clk;
  logic       reset;
  logic       init_req;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [4:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;

  logic [7:0] sb [$];
  logic [7:0] last_rdata;
  int         n_vec;
  int         n_bad;
  int         nb;
  int         rb;

  param_data_memory #(.DATA_W(8), .ADDR_W(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .init_req (init_req),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every response, checks hold otherwise.
  always @(negedge clk) begin
    if (reset) begin
      last_rdata = 8'h00;
    end else if (rsp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
      end else begin
        last_rdata = sb.pop_front();
        check("rsp_rdata", 32'(rsp_rdata), 32'(last_rdata));
      end
    end else begin
      check("rdata_hold", 32'(rsp_rdata), 32'(last_rdata));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [4:0] a, input logic [7:0] exp);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = a;
    sb.push_back(exp);
    tick();
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = a;
    req_wdata = d;
    tick();
  endtask

  task automatic drain(input string name);
    req_valid = 1'b0;
    tick();
    check(name, 32'(sb.size()), 32'd0);
  endtask

  // Counts cycles with busy = 1 (bounded); drops req_valid once idle.
  task automatic count_busy(output int n, output int rdy_bad);
    n = 0;
    rdy_bad = 0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      n++;
      if (req_ready) rdy_bad++;
      tick();
    end
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    last_rdata = 8'h00;
    reset = 1'b1;
    init_req = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;

    // Reset state, before any clock edge.
    #2;
    check("reset_busy", 32'(busy), 32'd1);
    check("reset_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
    tick();
    tick();
    reset = 1'b0;

    // Power-up init takes exactly 32 cycles.
    count_busy(nb, rb);
    check("init_busy_cycles", 32'(nb), 32'd32);
    check("init_ready_during_busy", 32'(rb), 32'd0);
    check("idle_ready", 32'(req_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    // Back-to-back reads across both halves of the pattern.
    do_read(5'd3, 8'h03);
    do_read(5'd17, 8'hFF);
    do_read(5'd31, 8'hF1);
    do_read(5'd0, 8'h00);
    drain("b2b_reads_drained");

    // Write then immediate read; read just before init_req still responds.
    do_write(5'd7, 8'hA5);
    do_read(5'd7, 8'hA5);
    do_read(5'd20, 8'hFC);
    req_valid = 1'b0;
    init_req = 1'b1;
    #1;
    check("ready_in_init_req_cycle", 32'(req_ready), 32'd0);
    tick();
    init_req = 1'b0;
    // Writes during INIT must not land; a second init_req must not restart.
    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = 5'd7;
    req_wdata = 8'hEE;
    tick();
    tick();
    tick();
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    count_busy(nb, rb);
    check("reinit_busy_cycles", 32'(nb + 4), 32'd32);
    check("reinit_ready_during_busy", 32'(rb), 32'd0);
    do_read(5'd7, 8'h07);
    do_read(5'd20, 8'hFC);
    drain("reinit_reads_drained");

    // Read held valid during INIT must not be accepted.
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 5'd5;
    count_busy(nb, rb);
    check("init3_busy_cycles", 32'(nb), 32'd32);
    tick();
    check("no_rsp_from_init_read", 32'(sb.size()), 32'd0);
    do_read(5'd5, 8'h05);
    drain("post_init_read_drained");

    // Reset at INIT cycle 10, held for 2 cycles.
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    #1;
    check("midinit_reset_busy", 32'(busy), 32'd1);
    check("midinit_reset_ready", 32'(req_ready), 32'd0);
    check("midinit_reset_rdata", 32'(rsp_rdata), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    count_busy(nb, rb);
    check("post_reset_busy_cycles", 32'(nb), 32'd32);
    do_read(5'd16, 8'h00);
    do_read(5'd7, 8'h07);
    do_read(5'd31, 8'hF1);
    drain("post_reset_reads_drained");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
